// File: rtl/mem_wb_unit_pkg.sv
// Shared types and constants for the memory-access / writeback back end.
package mem_wb_unit_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int unsigned ADDR_BASE_DEF = 1024;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned REG_W         = 4;
    localparam int unsigned WB_W          = 1 + REG_W + DATA_W;

    typedef struct packed {
        logic              en;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } wb_t;

endpackage

// File: rtl/mem_wb_unit_wb_pipe_reg.sv
// MEM/WB pipeline register; a bubble clears the whole slot.
module wb_pipe_reg
    import mem_wb_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              bubble_i,
    input  logic              wb_en_i,
    input  logic [REG_W-1:0]  dest_i,
    input  logic [DATA_W-1:0] value_i,
    output logic              wb_en_o,
    output logic [REG_W-1:0]  dest_o,
    output logic [DATA_W-1:0] value_o
);

    wb_t wb_q;
    wb_t wb_d;

    always_comb begin
        wb_d = wb_q;
        if (en_i) begin
            if (bubble_i) begin
                wb_d = '0;
            end else begin
                wb_d.en    = wb_en_i;
                wb_d.dest  = dest_i;
                wb_d.value = value_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_en_o = wb_q.en;
    assign dest_o  = wb_q.dest;
    assign value_o = wb_q.value;

endmodule

// File: rtl/mem_wb_unit.sv
// Data-memory access FSM with req/ack handshake, timeout and MEM/WB register.
module mem_wb_unit
    import mem_wb_unit_pkg::*;
#(
    parameter int unsigned ADDR_BASE = ADDR_BASE_DEF,
    parameter int unsigned WAIT_MAX  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [REG_W-1:0]  dest,
    input  logic              wb_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              freeze,
    output logic              wb_en_out,
    output logic [REG_W-1:0]  wb_dest_out,
    output logic [DATA_W-1:0] wb_value_out,
    output logic              mem_err
);

    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              err_q;
    logic              is_mem;
    logic              abort;
    logic              wb_load;
    logic [DATA_W-1:0] wb_value;
    logic [DATA_W-1:0] off;

    always_comb begin
        is_mem   = mem_r_en | mem_w_en;
        abort    = (state_q == ACCESS) && (cnt_q == CW'(WAIT_MAX));
        wb_load  = 1'b0;
        mem_req  = 1'b0;
        freeze   = 1'b0;
        unique case (state_q)
            IDLE: begin
                wb_load = !is_mem || mem_ack;
                mem_req = is_mem;
                freeze  = is_mem && !mem_ack;
            end
            ACCESS: begin
                wb_load = !abort && mem_ack;
                mem_req = !abort;
                freeze  = !abort && !mem_ack;
            end
            default: ;
        endcase
        // Outputs are forced quiet while reset is held, whatever upstream drives.
        if (rst) begin
            mem_req = 1'b0;
            freeze  = 1'b0;
        end
        wb_value = (is_mem && mem_r_en) ? mem_rdata : alu_result;
    end

    assign off       = alu_result - DATA_W'(ADDR_BASE);
    assign mem_addr  = {off[DATA_W-1:2], 2'b00};
    assign mem_we    = mem_req & mem_w_en;
    assign mem_wdata = val_rm;
    assign mem_err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_mem && !mem_ack) begin
                        state_q <= ACCESS;
                        cnt_q   <= '0;
                    end
                end
                ACCESS: begin
                    if (abort) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (mem_ack) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    wb_pipe_reg u_wb (
        .clk      (clk),
        .rst      (rst),
        .en_i     (1'b1),
        .bubble_i (!wb_load),
        .wb_en_i  (wb_en),
        .dest_i   (dest),
        .value_i  (wb_value),
        .wb_en_o  (wb_en_out),
        .dest_o   (wb_dest_out),
        .value_o  (wb_value_out)
    );

endmodule

// File: tb/tb_mem_wb_unit.sv
// Directed bench for mem_wb_unit; writebacks are checked by a scoreboard monitor.
module tb_mem_wb_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_result = '0;
    logic [31:0] val_rm = '0;
    logic [3:0]  dest = '0;
    logic        wb_en = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        freeze;
    logic        wb_en_out;
    logic [3:0]  wb_dest_out;
    logic [31:0] wb_value_out;
    logic        mem_err;

    int total = 0;
    int passed = 0;
    logic [35:0] exp_q[$];

    mem_wb_unit #(.ADDR_BASE(1024), .WAIT_MAX(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_result   (alu_result),
        .val_rm       (val_rm),
        .dest         (dest),
        .wb_en        (wb_en),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .freeze       (freeze),
        .wb_en_out    (wb_en_out),
        .wb_dest_out  (wb_dest_out),
        .wb_value_out (wb_value_out),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wb_en = 0; mem_r_en = 0; mem_w_en = 0;
        mem_ack = 0; mem_rdata = '0; dest = '0;
        alu_result = '0; val_rm = '0;
    endtask

    task automatic ldr(input logic [31:0] a, input logic [3:0] d);
        idle_in();
        alu_result = a; dest = d; wb_en = 1; mem_r_en = 1;
    endtask

    // Monitor: every register writeback must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (!rst && wb_en_out) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {28'd0, wb_dest_out}, 32'hFFFF_FFFF);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("wb_dest", {28'd0, wb_dest_out}, {28'd0, e[35:32]});
                chk("wb_value", wb_value_out, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout got running expected done");
        $fatal(1);
    end

    initial begin
        int fc;
        int nreq;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_en", {31'd0, wb_en_out}, 0);
        chk("rst_wb_dest", {28'd0, wb_dest_out}, 0);
        chk("rst_wb_value", wb_value_out, 0);
        chk("rst_req", {31'd0, mem_req}, 0);
        chk("rst_err", {31'd0, mem_err}, 0);
        rst = 0;

        // ALU op
        idle_in();
        alu_result = 32'h1234; dest = 3; wb_en = 1;
        #3;
        chk("alu_freeze", {31'd0, freeze}, 0);
        chk("alu_req", {31'd0, mem_req}, 0);
        exp_q.push_back({4'd3, 32'h1234});
        step();
        idle_in();

        // ack while idle is ignored
        mem_ack = 1;
        #3;
        chk("idle_ack_freeze", {31'd0, freeze}, 0);
        chk("idle_ack_req", {31'd0, mem_req}, 0);
        step();

        // LDR, ack on the fourth cycle
        ldr(1032, 5);
        fc = 0;
        #3;
        chk("ldr_addr", mem_addr, 8);
        chk("ldr_we", {31'd0, mem_we}, 0);
        chk("ldr_req", {31'd0, mem_req}, 1);
        fc += int'(freeze);
        step();
        for (int i = 0; i < 2; i++) begin
            #3;
            fc += int'(freeze);
            chk("ldr_stall_wb", {31'd0, wb_en_out}, 0);
            chk("ldr_addr_hold", mem_addr, 8);
            step();
        end
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        #3;
        fc += int'(freeze);
        exp_q.push_back({4'd5, 32'hDEADBEEF});
        step();
        idle_in();
        chk("ldr_freeze_cycles", fc, 3);

        // STR, ack in the first access cycle
        alu_result = 1028; val_rm = 32'hA5A5A5A5; mem_w_en = 1;
        #3;
        chk("str_we", {31'd0, mem_we}, 1);
        chk("str_addr", mem_addr, 4);
        chk("str_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("str_freeze0", {31'd0, freeze}, 1);
        step();
        mem_ack = 1;
        #3;
        chk("str_freeze1", {31'd0, freeze}, 0);
        step();
        idle_in();
        chk("str_no_wb", {31'd0, wb_en_out}, 0);

        // back-to-back loads
        ldr(1036, 6);
        step();
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        exp_q.push_back({4'd6, 32'h1111_1111});
        step();
        ldr(1040, 7);
        #3;
        chk("b2b_req", {31'd0, mem_req}, 1);
        chk("b2b_addr", mem_addr, 16);
        step();
        mem_ack = 1; mem_rdata = 32'h2222_2222;
        exp_q.push_back({4'd7, 32'h2222_2222});
        step();
        idle_in();

        // LDR never acknowledged
        ldr(1100, 8);
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (!mem_req) break;
            nreq++;
            step();
        end
        chk("abort_req_cycles", nreq, 16);
        chk("abort_freeze", {31'd0, freeze}, 0);
        step();
        idle_in();
        chk("abort_err", {31'd0, mem_err}, 1);
        alu_result = 32'h55; dest = 9; wb_en = 1;
        #3;
        chk("post_abort_freeze", {31'd0, freeze}, 0);
        exp_q.push_back({4'd9, 32'h55});
        step();
        idle_in();
        step();
        chk("err_sticky", {31'd0, mem_err}, 1);

        // reset in the middle of an access
        ldr(1032, 2);
        step();
        step();
        #2;
        rst = 1;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 0);
        chk("mid_rst_wb_en", {31'd0, wb_en_out}, 0);
        chk("mid_rst_value", wb_value_out, 0);
        chk("mid_rst_err", {31'd0, mem_err}, 0);
        step();
        idle_in();
        rst = 0;
        #3;
        chk("mid_rst_idle", {31'd0, freeze}, 0);
        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
